tournament_driver: RTL and testbench

Initiator side of the GA tournament-selection interface. Draws two random population indices from an internal LFSR, fetches their fitness values from the fitness RAM, and presents the pair to the `selection` comparator. It then captures the comparator's `selected` bit and hands the winning index to the crossover stage over a valid/ready handshake. It repeats this for a programmed number of parents per generation.

---
 rtl/tournament_driver.sv | 188 ++++++++++++++++++
 tb/tb_tournament_driver.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tournament_driver.sv
// ---------------------------------------------------------------------------
// tournament_driver
//
// Initiator side of the GA tournament-selection interface. For each parent
// of a batch it draws two distinct population indices from a 16-bit Galois
// LFSR, reads both fitness values from the fitness RAM, presents them to the
// external registered comparator, and hands the winning index to the
// crossover stage over a valid/ready handshake.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start          begins a batch (sampled only while idle)
//   num_parents    parents in the batch, latched with start
//   busy           high whenever a batch is in progress
//   done           one-cycle pulse when the batch completes
//   fit_rd_en      fitness RAM read strobe
//   fit_addr       fitness RAM address (holds when fit_rd_en is low)
//   fit_rdata      fitness RAM read data, valid the cycle after fit_rd_en
//   sel_fitness1   fitness of candidate A to the comparator
//   sel_fitness2   fitness of candidate B to the comparator
//   sel_enable     comparator enable, one cycle per tournament
//   sel_selected   comparator result: 0 = A strictly lower, 1 = B lower/equal
//   par_valid      winner index valid
//   par_ready      consumer accepts the winner
//   par_idx        winner index
// ---------------------------------------------------------------------------
module tournament_driver #(
    parameter int          POP_SIZE  = 32,      // power of two, <= 256
    parameter int          IDX_W     = 5,       // log2(POP_SIZE)
    parameter int          FIT_W     = 27,
    parameter logic [15:0] LFSR_SEED = 16'hACE1 // must be non-zero
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       num_parents,
    output logic             busy,
    output logic             done,
    output logic             fit_rd_en,
    output logic [IDX_W-1:0] fit_addr,
    input  logic [FIT_W-1:0] fit_rdata,
    output logic [FIT_W-1:0] sel_fitness1,
    output logic [FIT_W-1:0] sel_fitness2,
    output logic             sel_enable,
    input  logic             sel_selected,
    output logic             par_valid,
    input  logic             par_ready,
    output logic [IDX_W-1:0] par_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_CAPT,
        S_CMP,
        S_RES,
        S_OUT
    } state_t;

    state_t           state;
    logic [15:0]      lfsr;
    logic [15:0]      lfsr_nxt;
    logic [7:0]       remaining;
    logic [IDX_W-1:0] idx_a;
    logic [IDX_W-1:0] idx_b;

    // Right-shifting Galois LFSR, taps 16'hB400 (maximal length).
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] sh;
        sh = v >> 1;
        return v[0] ? (sh ^ 16'hB400) : sh;
    endfunction

    // Candidate B comes from the field just above candidate A. IDX_W never
    // exceeds 8, so both fields fit inside the 16-bit LFSR. A collision is
    // broken by stepping B to the next index, wrapping at POP_SIZE, so the
    // two candidates are always distinct.
    function automatic logic [IDX_W-1:0] pick_b(input logic [2*IDX_W-1:0] f);
        logic [IDX_W-1:0] a;
        logic [IDX_W-1:0] b;
        a = f[IDX_W-1:0];
        b = f[2*IDX_W-1:IDX_W];
        if (b == a) begin
            b = IDX_W'((int'(a) + 1) % POP_SIZE);
        end
        return b;
    endfunction

    assign lfsr_nxt = lfsr_step(lfsr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            lfsr         <= LFSR_SEED;
            remaining    <= '0;
            idx_a        <= '0;
            idx_b        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fit_rd_en    <= 1'b0;
            fit_addr     <= '0;
            sel_fitness1 <= '0;
            sel_fitness2 <= '0;
            sel_enable   <= 1'b0;
            par_valid    <= 1'b0;
            par_idx      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (num_parents != 8'd0) begin
                            // Candidates are latched on entry to RD_A, and
                            // the first read is launched on the same edge.
                            remaining <= num_parents;
                            idx_a     <= lfsr[IDX_W-1:0];
                            idx_b     <= pick_b(lfsr[2*IDX_W-1:0]);
                            fit_rd_en <= 1'b1;
                            fit_addr  <= lfsr[IDX_W-1:0];
                            busy      <= 1'b1;
                            state     <= S_RD_A;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end

                S_RD_A: begin
                    fit_addr <= idx_b;
                    state    <= S_RD_B;
                end

                S_RD_B: begin
                    // Data for candidate A arrives now.
                    fit_rd_en    <= 1'b0;
                    sel_fitness1 <= fit_rdata;
                    state        <= S_CAPT;
                end

                S_CAPT: begin
                    sel_fitness2 <= fit_rdata;
                    sel_enable   <= 1'b1;
                    state        <= S_CMP;
                end

                S_CMP: begin
                    sel_enable <= 1'b0;
                    state      <= S_RES;
                end

                S_RES: begin
                    // The comparator registered its result during CMP.
                    par_idx <= sel_selected ? idx_b : idx_a;
                    state   <= S_OUT;
                end

                S_OUT: begin
                    if (!par_valid) begin
                        par_valid <= 1'b1;
                    end else if (par_ready) begin
                        par_valid <= 1'b0;
                        remaining <= remaining - 8'd1;
                        lfsr      <= lfsr_nxt;
                        if (remaining == 8'd1) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            // Next tournament draws from the advanced LFSR.
                            idx_a     <= lfsr_nxt[IDX_W-1:0];
                            idx_b     <= pick_b(lfsr_nxt[2*IDX_W-1:0]);
                            fit_rd_en <= 1'b1;
                            fit_addr  <= lfsr_nxt[IDX_W-1:0];
                            state     <= S_RD_A;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tournament_driver.sv
module tb_tournament_driver;

    localparam int          POP  = 32;
    localparam int          IW   = 5;
    localparam int          FW   = 27;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] SEED_EQ = 16'h00A5; // low field 5, high field 5

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // Main DUT
    logic          start = 1'b0;
    logic [7:0]    num_parents = 8'd0;
    logic          busy, done, fit_rd_en, sel_enable, par_valid;
    logic [IW-1:0] fit_addr, par_idx;
    logic [FW-1:0] fit_rdata, sel_fitness1, sel_fitness2;
    logic          sel_selected;
    logic          par_ready = 1'b0;

    // Second DUT seeded so its first draw collides
    logic          start2 = 1'b0;
    logic [7:0]    num_parents2 = 8'd1;
    logic          busy2, done2, fit_rd_en2, sel_enable2, par_valid2;
    logic [IW-1:0] fit_addr2, par_idx2;
    logic [FW-1:0] fit_rdata2, sel_fitness1_2, sel_fitness2_2;
    logic          sel_selected2;
    logic          par_ready2 = 1'b1;

    tournament_driver #(.POP_SIZE(POP), .IDX_W(IW), .FIT_W(FW), .LFSR_SEED(SEED)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_parents(num_parents),
        .busy(busy), .done(done), .fit_rd_en(fit_rd_en), .fit_addr(fit_addr),
        .fit_rdata(fit_rdata), .sel_fitness1(sel_fitness1), .sel_fitness2(sel_fitness2),
        .sel_enable(sel_enable), .sel_selected(sel_selected), .par_valid(par_valid),
        .par_ready(par_ready), .par_idx(par_idx)
    );

    tournament_driver #(.POP_SIZE(POP), .IDX_W(IW), .FIT_W(FW), .LFSR_SEED(SEED_EQ)) u_dut_eq (
        .clk(clk), .rst_n(rst_n), .start(start2), .num_parents(num_parents2),
        .busy(busy2), .done(done2), .fit_rd_en(fit_rd_en2), .fit_addr(fit_addr2),
        .fit_rdata(fit_rdata2), .sel_fitness1(sel_fitness1_2), .sel_fitness2(sel_fitness2_2),
        .sel_enable(sel_enable2), .sel_selected(sel_selected2), .par_valid(par_valid2),
        .par_ready(par_ready2), .par_idx(par_idx2)
    );

    // Fitness RAMs (one-cycle read latency) and registered comparators
    logic [FW-1:0] mem [POP];

    always @(posedge clk) if (fit_rd_en) fit_rdata <= mem[fit_addr];
    always @(posedge clk) if (sel_enable) sel_selected <= (sel_fitness2 <= sel_fitness1);
    always @(posedge clk) if (fit_rd_en2) fit_rdata2 <= FW'(fit_addr2);
    always @(posedge clk) if (sel_enable2) sel_selected2 <= (sel_fitness2_2 <= sel_fitness1_2);

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: LFSR sequence and candidate/winner rules
    logic [15:0] m_lfsr;

    function automatic logic [15:0] m_step(input logic [15:0] v);
        return 16'(int'(v) / 2) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic void m_pick(input logic [15:0] v, output int a, output int b);
        a = int'(v) % POP;
        b = (int'(v) / POP) % POP;
        if (b == a) b = (a + 1) % POP;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {busy, done, fit_rd_en, sel_enable, par_valid}, 0);
        chk({tag, "_idx"}, {fit_addr, par_idx}, 0);
        chk({tag, "_fit"}, {sel_fitness1, sel_fitness2}, 0);
    endtask

    // stall < 0 selects a random stall of 0..3 cycles per parent
    task automatic run_batch(input int n, input int stall);
        int a, b, w, k, s;
        @(negedge clk);
        num_parents = 8'(n);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int p = 0; p < n; p++) begin
            m_pick(m_lfsr, a, b);
            w = (mem[b] <= mem[a]) ? b : a;
            k = 0;
            while (!par_valid && k < 40) begin
                if (k == 0) chk("rd_a", {fit_rd_en, fit_addr}, {1'b1, IW'(a)});
                if (k == 1) chk("rd_b", {fit_rd_en, fit_addr}, {1'b1, IW'(b)});
                if (k == 3) begin
                    chk("cmp_en", {sel_enable, fit_rd_en}, 2'b10);
                    chk("fit1", sel_fitness1, mem[a]);
                    chk("fit2", sel_fitness2, mem[b]);
                end
                @(negedge clk);
                k++;
            end
            chk("latency", k, 6);
            if (!par_valid) return;
            chk("par_idx", par_idx, w);
            s = (stall < 0) ? $urandom_range(0, 3) : stall;
            for (int i = 0; i < s; i++) begin
                @(negedge clk);
                chk("hold", {busy, par_valid, fit_rd_en, par_idx}, {2'b11, 1'b0, IW'(w)});
            end
            par_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            par_ready = 1'b0;
            m_lfsr = m_step(m_lfsr);
            if (p == n - 1) chk("done_last", {done, busy, par_valid}, 3'b100);
            else            chk("done_mid", {done, busy}, 2'b01);
        end
        @(negedge clk);
        chk("done_pulse", {done, busy}, 2'b00);
    endtask

    initial begin
        int a, b, k;

        // Reset
        #2 rst_n = 1'b0;
        #1 chk_zero("reset");
        repeat (3) @(negedge clk);
        chk_zero("reset_clk");
        rst_n = 1'b1;
        m_lfsr = SEED;

        // Ascending fitness, single parent: winner is the smaller index
        for (int i = 0; i < POP; i++) mem[i] = FW'(i);
        run_batch(1, 0);

        // All fitness equal: ties go to candidate B
        for (int i = 0; i < POP; i++) mem[i] = 27'h7FFFFFF;
        run_batch(4, 0);

        // Long stall in OUT
        for (int i = 0; i < POP; i++) mem[i] = FW'(i);
        run_batch(2, 20);

        // Colliding candidate fields on the second instance
        m_pick(SEED_EQ, a, b);
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        chk("eq_rd_a", {fit_rd_en2, fit_addr2}, {1'b1, IW'(a)});
        @(negedge clk);
        chk("eq_rd_b", {fit_rd_en2, fit_addr2}, {1'b1, IW'(b)});
        k = 1;
        while (!par_valid2 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("eq_latency", k, 6);
        chk("eq_par_idx", par_idx2, (b < a) ? b : a);
        repeat (3) @(negedge clk);

        // Random fitness, random batch sizes and stalls
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < POP; i++) mem[i] = FW'($urandom) | 27'd1;
            run_batch(int'($urandom_range(1, 5)), -1);
        end

        // Zero-parent start
        @(negedge clk);
        num_parents = 8'd0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("zero_done", {done, busy, fit_rd_en}, 3'b100);
        @(negedge clk);
        chk("zero_after", {done, busy, fit_rd_en}, 3'b000);

        // Reset during CMP of an 8-parent batch, then replay from the seed
        @(negedge clk);
        num_parents = 8'd8;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_cmp", {busy, sel_enable}, 2'b11);
        #1 rst_n = 1'b0;
        #1 chk_zero("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        m_lfsr = SEED;
        run_batch(8, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
